// File: rtl/sram_col_ctrl.sv
// sram_col_ctrl: precharge -> wordline -> release sequencer for a weak-drive SRAM column array
module sram_col_ctrl #(
  parameter int NROW    = 4,
  parameter int WIDTH   = 8,
  parameter int ADDR_W  = 3,
  parameter int PRE_CYC = 2,
  parameter int ACC_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              rsp_valid,
  output logic [WIDTH-1:0]  rsp_rdata,
  output logic              rsp_err,
  output logic [NROW-1:0]   wl,
  inout  wire  [WIDTH-1:0]  lbl,
  inout  wire  [WIDTH-1:0]  lblb
);
  localparam int MAXC = PRE_CYC > ACC_CYC ? PRE_CYC : ACC_CYC;
  localparam int CW = $clog2(MAXC) + 1;
  typedef enum logic [2:0] {IDLE, PRE, ACC, HOLD, RESP} state_t;
  state_t            state;
  logic [CW-1:0]     cnt;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  wdata;
  logic              drv;
  logic [WIDTH-1:0]  dv;
  logic [WIDTH-1:0]  dvb;
  logic              ok;
  assign ok = {1'b0, addr} < (ADDR_W+1)'(NROW);
  assign lbl = drv ? dv : 'z;
  assign lblb = drv ? dvb : 'z;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      we <= 1'b0;
      addr <= '0;
      wdata <= '0;
      drv <= 1'b0;
      dv <= '0;
      dvb <= '0;
      wl <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          state <= PRE;
          we <= req_we;
          addr <= req_addr;
          wdata <= req_wdata;
          cnt <= CW'(PRE_CYC - 1);
          drv <= 1'b1;
          dv <= '1;
          dvb <= '1;
          req_ready <= 1'b0;
          rsp_rdata <= '0;
          rsp_err <= 1'b0;
        end
        PRE: if (cnt == '0) begin
          // precharge drive is released on the very edge the wordline rises
          state <= ACC;
          cnt <= CW'(ACC_CYC - 1);
          wl <= ok ? NROW'(1) << addr : '0;
          drv <= we && ok;
          dv <= wdata;
          dvb <= ~wdata;
        end else cnt <= cnt - 1'b1;
        ACC: if (cnt == '0) begin
          state <= HOLD;
          wl <= '0;
          rsp_rdata <= (we || !ok) ? '0 : lbl;
          rsp_err <= !ok || (!we && ((|(lbl ~^ lblb)) || $isunknown({lbl, lblb})));
        end else cnt <= cnt - 1'b1;
        HOLD: begin
          state <= RESP;
          drv <= 1'b0;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          state <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_col_ctrl.sv
// tb_sram_col_ctrl: scoreboard bench driving sram_col_ctrl over a behavioural 4x8 bitcell array
module tb_sram_col_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [2:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic [3:0] wl;
  wire  [7:0] lbl;
  wire  [7:0] lblb;

  sram_col_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wl(wl), .lbl(lbl), .lblb(lblb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // bitcell array: drives its row only on reads of a written cell, latches lines on writes
  logic [7:0] mem [4];
  logic [3:0] vld = '0;
  logic       tb_wr = 1'b0;
  logic       cen;
  logic [7:0] cval;
  always_comb begin
    cen = 1'b0;
    cval = '0;
    for (int r = 0; r < 4; r++)
      if (wl[r] && !tb_wr && vld[r]) begin
        cen = 1'b1;
        cval = mem[r];
      end
  end
  assign lbl = cen ? cval : 'z;
  assign lblb = cen ? ~cval : 'z;
  always @(posedge clk)
    for (int r = 0; r < 4; r++)
      if (wl[r] && tb_wr) begin
        mem[r] <= lbl;
        vld[r] <= 1'b1;
      end

  int tests = 0;
  int fails = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int         cyc;
    logic [7:0] rd;
    logic       err;
    bit         dc;
    int         wln;
    logic [3:0] wlv;
  } exp_t;
  exp_t       sb [$];
  logic [7:0] model [8];
  bit   [7:0] mvld = '0;

  function automatic void push_exp(input logic we, input logic [2:0] a, input logic [7:0] d, input int acc);
    exp_t e;
    bit ok;
    ok = a < 4;
    e.cyc = acc + 5;
    e.wln = ok ? 2 : 0;
    e.wlv = ok ? 4'(1) << a : 4'h0;
    e.dc = 1'b0;
    e.rd = 8'h00;
    e.err = !ok;
    if (we && ok) begin
      model[a] = d;
      mvld[a] = 1'b1;
    end else if (!we && ok) begin
      e.rd = model[a];
      e.err = !mvld[a];
      e.dc = !mvld[a];
    end
    sb.push_back(e);
  endfunction

  int   wl_n = 0;
  logic wl_bad = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      wl_n = 0;
      wl_bad = 1'b0;
    end else begin
      if (wl != 4'h0) begin
        wl_n++;
        if (sb.size() > 0 && wl !== sb[0].wlv) wl_bad = 1'b1;
      end
      if (rsp_valid) begin
        if (sb.size() == 0) chk("extra_rsp", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_cyc", cyc, e.cyc);
          chk("rsp_err", rsp_err, e.err);
          if (!e.dc) chk("rsp_rdata", rsp_rdata, e.rd);
          chk("wl_cycles", wl_n, e.wln);
          chk("wl_row", wl_bad, 0);
        end
        wl_n = 0;
        wl_bad = 1'b0;
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] a, input logic [7:0] d, input bit push, output int acc);
    req_we = we;
    req_addr = a;
    req_wdata = d;
    tb_wr = we;
    req_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 50 && acc < 0; i++)
      if (req_ready) acc = cyc + 1;
      else @(negedge clk);
    if (acc < 0) chk("accept_timeout", 1, 0);
    else if (push) push_exp(we, a, d, acc);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
    chk("pending", sb.size(), 0);
    sb.delete();
    @(negedge clk);
  endtask

  int a1, a2;
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_wl", wl, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    rst = 1'b0;
    @(negedge clk);
    issue(1, 2, 8'hA5, 1, a1);
    wait_idle();
    issue(0, 2, 8'h00, 1, a1);
    chk("pre_lines", {lbl, lblb}, 16'hFFFF);
    wait_idle();
    issue(1, 1, 8'h3C, 1, a1);
    wait_idle();
    issue(0, 1, 8'h00, 1, a1);
    wait_idle();
    issue(0, 2, 8'h00, 1, a1);
    wait_idle();
    issue(0, 0, 8'h00, 1, a1);
    wait_idle();
    issue(0, 5, 8'h00, 1, a1);
    wait_idle();
    issue(1, 6, 8'hFF, 1, a1);
    wait_idle();
    // request held valid across a busy access
    req_we = 1'b0;
    req_addr = 3'd1;
    tb_wr = 1'b0;
    req_valid = 1'b1;
    a1 = cyc + 1;
    chk("b2b_first_ready", req_ready, 1);
    push_exp(0, 1, 8'h00, a1);
    @(negedge clk);
    chk("busy_ready", req_ready, 0);
    a2 = -1;
    for (int i = 0; i < 20 && a2 < 0; i++)
      if (req_ready) a2 = cyc + 1;
      else @(negedge clk);
    chk("b2b_period", a2 - a1, 7);
    if (a2 >= 0) push_exp(0, 1, 8'h00, a2);
    @(negedge clk);
    req_valid = 1'b0;
    wait_idle();
    // reset in the middle of a write access
    issue(1, 3, 8'h77, 0, a1);
    @(negedge clk);
    @(negedge clk);
    chk("acc_wl", wl, 4'b1000);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_wl", wl, 0);
    chk("abort_ready", req_ready, 1);
    chk("abort_valid", rsp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    issue(0, 2, 8'h00, 1, a1);
    wait_idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
